// File: rtl/playback_timer_controller.sv
// Playback timer sequencer: STOP/PLAY/PAUSE/SEEK control of a BCD m:ss Timer from debounced buttons.
// Optional hold-to-repeat seeking is enabled by defining AUTOREPEAT_EN.
module playback_timer_controller #(
   parameter int SEEK_STEP   = 10,
   parameter int MAX_SECONDS = 599
`ifdef AUTOREPEAT_EN
   , parameter int REPEAT_CYCLES = 25_000_000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play_btn,
   input  logic       stop_btn,
   input  logic       fwd_btn,
   input  logic       rew_btn,
   input  logic [3:0] seconds0,
   input  logic [3:0] seconds1,
   input  logic [3:0] minutes0,
   output logic       timer_count,
   output logic       timer_reset,
   output logic [8:0] timer_adder,
   output logic [1:0] state,
   output logic       at_end
);

   localparam logic [1:0] ST_STOP  = 2'b00;
   localparam logic [1:0] ST_PLAY  = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_SEEK  = 2'b11;
   localparam logic [9:0] MAX_C    = 10'(MAX_SECONDS);
   localparam logic [7:0] STEP_C   = 8'(SEEK_STEP);

   logic       play_q_r, stop_q_r, fwd_q_r, rew_q_r;
   logic       ret_play_r;
   logic       play_press_s, stop_press_s, fwd_press_s, rew_press_s;
   logic       fwd_edge_s, rew_edge_s, any_press_s;
   logic [9:0] cur_s, room_s;
   logic [7:0] fwd_mag_s, rew_mag_s;
   logic [8:0] fwd_step_s, rew_step_s;
   logic [1:0] next_state_s;
   logic       next_count_s, next_reset_s, next_end_s, next_ret_s;
   logic [8:0] next_adder_s;

   // Edge detection, current time and clamped seek steps
   always_comb begin
      play_press_s = play_btn & ~play_q_r;
      stop_press_s = stop_btn & ~stop_q_r;
      fwd_edge_s   = fwd_btn & ~fwd_q_r;
      rew_edge_s   = rew_btn & ~rew_q_r;
      cur_s = ({6'd0, minutes0} * 10'd60) + ({6'd0, seconds1} * 10'd10) + {6'd0, seconds0};
      room_s = (cur_s >= MAX_C) ? 10'd0 : (MAX_C - cur_s);
      fwd_mag_s  = (room_s < {2'b00, STEP_C}) ? room_s[7:0] : STEP_C;
      rew_mag_s  = (cur_s < {2'b00, STEP_C}) ? cur_s[7:0] : STEP_C;
      fwd_step_s = {1'b0, fwd_mag_s};
      rew_step_s = 9'd0 - {1'b0, rew_mag_s};
   end

`ifdef AUTOREPEAT_EN
   localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] hold_cnt_r;
   logic             held_s, rep_fire_s, hold_clear_s;

   // Synthetic presses from a held seek button; real edges take precedence
   always_comb begin
      held_s     = fwd_btn | rew_btn;
      rep_fire_s = held_s && ((state == ST_PLAY) || (state == ST_PAUSE))
                   && (hold_cnt_r == CNT_LAST) && !(fwd_edge_s | rew_edge_s);
      fwd_press_s  = fwd_edge_s | (rep_fire_s & fwd_btn);
      rew_press_s  = rew_edge_s | (rep_fire_s & ~fwd_btn & rew_btn);
      hold_clear_s = (next_state_s != state) && (next_state_s != ST_SEEK) && (state != ST_SEEK);
   end

   // Hold counter: restarts on every seek press, clears on release or a real state change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt_r <= '0;
      end else if (!held_s || (state == ST_STOP) || hold_clear_s
                   || fwd_edge_s || rew_edge_s || rep_fire_s) begin
         hold_cnt_r <= '0;
      end else if (hold_cnt_r != CNT_LAST) begin
         hold_cnt_r <= hold_cnt_r + 1'b1;
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end
`else
   // Seeks come from button edges only
   always_comb begin
      fwd_press_s = fwd_edge_s;
      rew_press_s = rew_edge_s;
   end
`endif

   // Next-state and next-output decode with stop > play > fwd > rew priority
   always_comb begin
      any_press_s  = play_press_s | stop_press_s | fwd_press_s | rew_press_s;
      next_state_s = state;
      next_count_s = 1'b0;
      next_reset_s = 1'b0;
      next_adder_s = 9'd0;
      next_end_s   = 1'b0;
      next_ret_s   = ret_play_r;
      case (state)
         ST_STOP: begin
            if (play_press_s) begin
               next_state_s = ST_PLAY;
               next_count_s = 1'b1;
            end else begin
               next_state_s = ST_STOP;
            end
         end
         ST_PLAY, ST_PAUSE: begin
            if (stop_press_s) begin
               next_state_s = ST_STOP;
               next_reset_s = 1'b1;
            end else if (play_press_s) begin
               next_state_s = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
               next_count_s = (state == ST_PAUSE);
            end else if (fwd_press_s && (fwd_step_s != 9'd0)) begin
               next_state_s = ST_SEEK;
               next_adder_s = fwd_step_s;
               next_ret_s   = (state == ST_PLAY);
            end else if (!fwd_press_s && rew_press_s && (rew_step_s != 9'd0)) begin
               next_state_s = ST_SEEK;
               next_adder_s = rew_step_s;
               next_ret_s   = (state == ST_PLAY);
            end else if ((state == ST_PLAY) && !any_press_s && (cur_s == MAX_C)) begin
               next_state_s = ST_STOP;
               next_reset_s = 1'b1;
               next_end_s   = 1'b1;
            end else begin
               next_count_s = (state == ST_PLAY);
            end
         end
         ST_SEEK: begin
            if (stop_press_s) begin
               next_state_s = ST_STOP;
               next_reset_s = 1'b1;
            end else if (ret_play_r) begin
               next_state_s = ST_PLAY;
               next_count_s = 1'b1;
            end else begin
               next_state_s = ST_PAUSE;
            end
         end
         default: begin
            next_state_s = ST_STOP;
            next_reset_s = 1'b1;
         end
      endcase
   end

   // Registered outputs, button history and seek origin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_STOP;
         timer_count <= 1'b0;
         timer_reset <= 1'b1;
         timer_adder <= 9'd0;
         at_end      <= 1'b0;
         ret_play_r  <= 1'b0;
         play_q_r    <= 1'b0;
         stop_q_r    <= 1'b0;
         fwd_q_r     <= 1'b0;
         rew_q_r     <= 1'b0;
      end else begin
         state       <= next_state_s;
         timer_count <= next_count_s;
         timer_reset <= next_reset_s;
         timer_adder <= next_adder_s;
         at_end      <= next_end_s;
         ret_play_r  <= next_ret_s;
         play_q_r    <= play_btn;
         stop_q_r    <= stop_btn;
         fwd_q_r     <= fwd_btn;
         rew_q_r     <= rew_btn;
      end
   end

endmodule

// File: tb/tb_playback_timer_controller.sv
// Self-checking bench for playback_timer_controller: vector table plus hand-written corner sequences.
// Define AUTOREPEAT_EN to also check hold-to-repeat seeking with REPEAT_CYCLES=4.
module tb_playback_timer_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       play_btn = 1'b0, stop_btn = 1'b0, fwd_btn = 1'b0, rew_btn = 1'b0;
   logic [3:0] seconds0 = 4'd0, seconds1 = 4'd0, minutes0 = 4'd0;
   logic       timer_count, timer_reset, at_end;
   logic [8:0] timer_adder;
   logic [1:0] state;

   typedef struct {
      logic       play, stop, fwd, rew;
      logic [3:0] m0, s1, s0;
      logic [1:0] st;
      logic       cnt, trst;
      logic [8:0] add;
      logic       fin;
   } vec_t;

   typedef struct {
      int          idx;
      logic [13:0] val;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   playback_timer_controller #(
      .SEEK_STEP(10),
      .MAX_SECONDS(599)
`ifdef AUTOREPEAT_EN
      , .REPEAT_CYCLES(4)
`endif
   ) dut (
      .clk(clk), .reset(reset),
      .play_btn(play_btn), .stop_btn(stop_btn), .fwd_btn(fwd_btn), .rew_btn(rew_btn),
      .seconds0(seconds0), .seconds1(seconds1), .minutes0(minutes0),
      .timer_count(timer_count), .timer_reset(timer_reset), .timer_adder(timer_adder),
      .state(state), .at_end(at_end)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [13:0] pack(input logic [1:0] st, input logic c, input logic t,
                                        input logic [8:0] a, input logic e);
      return {st, c, t, a, e};
   endfunction

   task automatic check(input string name, input int idx, input logic [13:0] act, input logic [13:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s #%0d: got st=%b cnt=%b rst=%b add=%h end=%b, want st=%b cnt=%b rst=%b add=%h end=%b",
                  name, idx, act[13:12], act[11], act[10], act[9:1], act[0],
                  req[13:12], req[11], req[10], req[9:1], req[0]);
      end
   endtask

   task automatic addv(input logic p, s, f, r, input logic [3:0] m0, s1, s0,
                       input logic [1:0] st, input logic c, t, input logic [8:0] a, input logic e);
      vec_t v;
      v.play = p; v.stop = s; v.fwd = f; v.rew = r;
      v.m0 = m0; v.s1 = s1; v.s0 = s0;
      v.st = st; v.cnt = c; v.trst = t; v.add = a; v.fin = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the sampling edge
   task automatic apply(input string name, input int idx, input vec_t v);
      exp_t e;
      @(negedge clk);
      play_btn = v.play; stop_btn = v.stop; fwd_btn = v.fwd; rew_btn = v.rew;
      minutes0 = v.m0; seconds1 = v.s1; seconds0 = v.s0;
      e.idx = idx;
      e.val = pack(v.st, v.cnt, v.trst, v.add, v.fin);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s #%0d: scoreboard empty", name, idx);
      end else begin
         e = exp_q.pop_front();
         check(name, e.idx, pack(state, timer_count, timer_reset, timer_adder, at_end), e.val);
      end
   endtask

   initial begin
      vec_t h;
      bit   rep_en;
`ifdef AUTOREPEAT_EN
      rep_en = 1'b1;
`else
      rep_en = 1'b0;
`endif
      //    p     s     f     r     m0    s1    s0    st     c     t     add      e
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd5, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd5, 2'b11, 1'b0, 1'b0, 9'h00A, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd5, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd5, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 2'b11, 1'b0, 1'b0, 9'h1FC, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b11, 1'b0, 1'b0, 9'h00A, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd5, 4'd5, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd5, 4'd5, 2'b11, 1'b0, 1'b0, 9'h004, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd5, 4'd9, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd5, 4'd9, 2'b00, 1'b0, 1'b1, 9'h000, 1'b1);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd5, 4'd9, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd5, 4'd9, 2'b00, 1'b0, 1'b1, 9'h000, 1'b1);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 2'b11, 1'b0, 1'b0, 9'h00A, 1'b0);
      addv(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 4'd0, 2'b00, 1'b0, 1'b1, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
      addv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 4'd0, 2'b11, 1'b0, 1'b0, 9'h00A, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 2'b11, 1'b0, 1'b0, 9'h1F6, 1'b0);
      addv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);

      // Reset state while reset is held
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 0, pack(state, timer_count, timer_reset, timer_adder, at_end),
            pack(2'b00, 1'b0, 1'b1, 9'h000, 1'b0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply("vec", i, vecs[i]);
      end

      // Seek button held for 13 cycles in PAUSE at 0:00
      h = vecs[0];
      for (int k = 0; k < 13; k++) begin
         h.fwd = 1'b1;
         if ((k == 0) || (rep_en && (k % 4 == 0))) begin
            h.st = 2'b11; h.add = 9'h00A;
         end else begin
            h.st = 2'b10; h.add = 9'h000;
         end
         apply("hold_fwd", k, h);
      end
      h.fwd = 1'b0; h.st = 2'b10; h.add = 9'h000;
      apply("hold_release", 0, h);

      // Asynchronous reset in the middle of a SEEK cycle
      h.fwd = 1'b1; h.s1 = 4'd3; h.st = 2'b11; h.add = 9'h00A;
      apply("pre_abort_seek", 0, h);
      reset = 1'b1;
      fwd_btn = 1'b0;
      #1;
      check("abort_seek", 0, pack(state, timer_count, timer_reset, timer_adder, at_end),
            pack(2'b00, 1'b0, 1'b1, 9'h000, 1'b0));
      @(negedge clk);
      reset = 1'b0;
      h = vecs[0];
      apply("post_abort", 0, h);
      apply("post_abort", 1, h);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
